mux_acc_adder: RTL and testbench

Parametrised successor to the 2-bit mux/flop/full-adder microtile. Selects one of two operand pairs, registers them, and computes ADD, SUB, ACCUMULATE or XOR on WIDTH-bit operands through a 2-stage valid-tagged pipeline. Flags are carry/borrow, signed overflow and operand parity. Sits directly behind the tile's ui_in/uio_in pins; results drive uo_out/uio_out.

---
 rtl/mux_acc_pkg.sv | 14 +
 rtl/mux_acc_adder_if.sv | 35 +++
 rtl/rca_adder.sv | 25 ++
 rtl/mux_acc_adder.sv | 111 +++++++++++
 tb/tb_mux_acc_adder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_acc_pkg.sv
// Shared types and constants for the mux/accumulate/adder tile.
package mux_acc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ACC = 2'b01,
        MODE_SUB = 2'b10,
        MODE_XOR = 2'b11
    } mode_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 16;

endpackage

// File: rtl/mux_acc_adder_if.sv
// Request/result bundle between the tile pins and the mux_acc_adder datapath.
interface mux_acc_adder_if #(
    parameter int unsigned WIDTH = 4
) ();
    import mux_acc_pkg::*;

    logic             in_valid;
    logic             sel;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] b1;
    logic             cin;
    mode_e            mode;
    logic             acc_clr;

    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;
    logic             q_par;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, sel, a0, a1, b0, b1, cin, mode, acc_clr,
        input  q_a, q_b, q_par, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, sel, a0, a1, b0, b1, cin, mode, acc_clr,
        output q_a, q_b, q_par, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/rca_adder.sv
// Ripple-carry adder built from full-adder cells; exposes the MSB carry-in for overflow.
module rca_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout    = carry[WIDTH];
    assign msb_cin = carry[WIDTH-1];

endmodule

// File: rtl/mux_acc_adder.sv
// Two-stage operand-select / ADD-ACC-SUB-XOR pipeline with a running accumulator.
module mux_acc_adder
    import mux_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_acc_adder_if.slave  bus
);

    logic [WIDTH-1:0] q_a_q, q_b_q, acc_q, sum_q;
    logic [WIDTH-1:0] sum_d, base, op1, op2, add_sum;
    logic             s1_valid_q, s1_cin_q, s1_clr_q;
    logic             out_valid_q, cout_q, ovf_q;
    logic             cout_d, ovf_d, add_ci, add_cout, add_msb_cin;
    mode_e            s1_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            q_a_q      <= '0;
            q_b_q      <= '0;
            s1_mode_q  <= MODE_ADD;
            s1_cin_q   <= 1'b0;
            s1_clr_q   <= 1'b0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                q_a_q     <= bus.sel ? bus.a1 : bus.a0;
                q_b_q     <= bus.sel ? bus.b1 : bus.b0;
                s1_mode_q <= bus.mode;
                s1_cin_q  <= bus.cin;
                s1_clr_q  <= bus.acc_clr;
            end
        end
    end

    // One adder serves ADD/ACC/SUB; mode only steers operand-2 and carry-in.
    always_comb begin
        base   = s1_clr_q ? '0 : acc_q;
        op1    = q_a_q;
        op2    = q_b_q;
        add_ci = s1_cin_q;
        unique case (s1_mode_q)
            MODE_ADD: ;
            MODE_ACC: begin
                op1 = base;
                op2 = q_a_q;
            end
            MODE_SUB: begin
                op2    = ~q_b_q;
                add_ci = 1'b1;
            end
            MODE_XOR: ;
        endcase
    end

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a       (op1),
        .b       (op2),
        .cin     (add_ci),
        .sum     (add_sum),
        .cout    (add_cout),
        .msb_cin (add_msb_cin)
    );

    always_comb begin
        sum_d  = add_sum;
        cout_d = add_cout;
        ovf_d  = add_cout ^ add_msb_cin;
        if (s1_mode_q == MODE_XOR) begin
            sum_d  = q_a_q ^ q_b_q;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                if (s1_mode_q == MODE_ACC) begin
                    acc_q <= add_sum;
                end else if (s1_clr_q) begin
                    acc_q <= '0;
                end
            end
        end
    end

    assign bus.q_a       = q_a_q;
    assign bus.q_b       = q_b_q;
    assign bus.q_par     = ^{q_a_q, q_b_q};
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mux_acc_adder.sv
// Directed bench for mux_acc_adder at WIDTH=4; results packed as {out_valid, sum, cout, ovf}.
module tb_mux_acc_adder;
    import mux_acc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mux_acc_adder_if #(.WIDTH(4)) bus ();

    mux_acc_adder #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic s, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] a1, input logic [3:0] b1, input logic c,
                           input mode_e m, input logic clr);
        bus.in_valid = v;
        bus.sel      = s;
        bus.a0       = a0;
        bus.b0       = b0;
        bus.a1       = a1;
        bus.b1       = b1;
        bus.cin      = c;
        bus.mode     = m;
        bus.acc_clr  = clr;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic test_reset();
        set_req(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, MODE_ADD, 1'b0);
        rst = 1'b1;
        step();
        step();
        idle();
        rst = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== 7'h00) begin
            n_errors++;
            $display("FAIL reset_result: got %b required 0000000",
                     {bus.out_valid, bus.sum, bus.cout, bus.ovf});
        end
        n_checks++;
        if ({bus.q_a, bus.q_b, bus.q_par} !== 9'h000) begin
            n_errors++;
            $display("FAIL reset_stage1: got %b required 000000000", {bus.q_a, bus.q_b, bus.q_par});
        end
    endtask

    task automatic test_add();
        set_req(1'b1, 1'b0, 4'h9, 4'h8, 4'h1, 4'h1, 1'b1, MODE_ADD, 1'b0);
        step();
        idle();
        // 1001 and 1000 contain three ones in total
        n_checks++;
        if ({bus.q_a, bus.q_b, bus.q_par, bus.out_valid} !== {4'h9, 4'h8, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL add_stage1: got %h/%h par %b v %b required 9/8 par 1 v 0",
                     bus.q_a, bus.q_b, bus.q_par, bus.out_valid);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 4'h2, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL add_result: got v%b s%h c%b o%b required v1 s2 c1 o1",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.q_a} !== {1'b0, 4'h2, 4'h9}) begin
            n_errors++;
            $display("FAIL add_hold: got v%b s%h qa%h required v0 s2 qa9",
                     bus.out_valid, bus.sum, bus.q_a);
        end
    endtask

    task automatic test_sub();
        logic [3:0] av [3] = '{4'h3, 4'h7, 4'h8};
        logic [3:0] bv [3] = '{4'h5, 4'h2, 4'h1};
        logic [6:0] ex [3] = '{{1'b1, 4'hE, 1'b0, 1'b0},
                               {1'b1, 4'h5, 1'b1, 1'b0},
                               {1'b1, 4'h7, 1'b1, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            // sel=1 with decoy values on the sel=0 inputs; cin must be ignored
            set_req(1'b1, 1'b1, 4'hF, 4'hF, av[i], bv[i], 1'b1, MODE_SUB, 1'b0);
            step();
            idle();
            step();
            n_checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== ex[i]) begin
                n_errors++;
                $display("FAIL sub_%0d: got %b required %b", i,
                         {bus.out_valid, bus.sum, bus.cout, bus.ovf}, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back_acc();
        logic [6:0] ex [3] = '{{1'b1, 4'h7, 1'b0, 1'b0},
                               {1'b1, 4'hE, 1'b0, 1'b1},
                               {1'b1, 4'h5, 1'b1, 1'b0}};
        set_req(1'b1, 1'b0, 4'h7, 4'h0, 4'h0, 4'h0, 1'b0, MODE_ACC, 1'b1);
        step();
        bus.acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) idle();
            step();
            n_checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== ex[i]) begin
                n_errors++;
                $display("FAIL acc_chain_%0d: got %b required %b", i,
                         {bus.out_valid, bus.sum, bus.cout, bus.ovf}, ex[i]);
            end
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL acc_chain_end: out_valid got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_xor();
        set_req(1'b1, 1'b0, 4'hA, 4'h6, 4'h0, 4'h0, 1'b1, MODE_XOR, 1'b0);
        step();
        idle();
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 4'hC, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL xor_result: got %b required 1110000",
                     {bus.out_valid, bus.sum, bus.cout, bus.ovf});
        end
        bus.a0 = 4'h1;
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.q_a} !== {1'b0, 4'hC, 4'hA}) begin
            n_errors++;
            $display("FAIL xor_hold: got v%b s%h qa%h required v0 sC qaA",
                     bus.out_valid, bus.sum, bus.q_a);
        end
    endtask

    // Reads acc back through an ACC op with A=0, cin=0, no clear.
    task automatic probe_acc(input logic [3:0] exp_acc, input string name);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, MODE_ACC, 1'b0);
        step();
        idle();
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum} !== {1'b1, exp_acc}) begin
            n_errors++;
            $display("FAIL %s: got v%b acc %h required v1 acc %h", name, bus.out_valid, bus.sum,
                     exp_acc);
        end
    endtask

    task automatic test_acc_clear();
        set_req(1'b1, 1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, MODE_ACC, 1'b1);
        step();
        set_req(1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, MODE_ACC, 1'b1);
        step();
        idle();
        n_checks++;
        if (bus.sum !== 4'h5) begin
            n_errors++;
            $display("FAIL acc_preload: got %h required 5", bus.sum);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 4'h4, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL acc_clr_acc: got %b required 1010000",
                     {bus.out_valid, bus.sum, bus.cout, bus.ovf});
        end
        probe_acc(4'h4, "acc_after_clr");
        // Clear alongside ADD: ADD result unaffected, acc zeroed
        set_req(1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, MODE_ADD, 1'b1);
        step();
        idle();
        step();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 4'h2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL add_with_clr: got %b required 1001000",
                     {bus.out_valid, bus.sum, bus.cout, bus.ovf});
        end
        probe_acc(4'h0, "acc_after_add_clr");
    endtask

    task automatic test_reset_midflight();
        set_req(1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, MODE_ACC, 1'b1);
        step();
        bus.acc_clr = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        n_checks++;
        if ({bus.out_valid, bus.sum, bus.q_a, bus.q_b} !== 13'h0) begin
            n_errors++;
            $display("FAIL midflight_reset: got v%b s%h qa%h qb%h required all 0",
                     bus.out_valid, bus.sum, bus.q_a, bus.q_b);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midflight_after: out_valid got %b required 0", bus.out_valid);
        end
        probe_acc(4'h0, "acc_after_reset");
    endtask

    initial begin
        set_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, MODE_ADD, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_back_to_back_acc();
        test_xor();
        test_acc_clear();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
